// File: rtl/period_meter_pkg.sv
// period_meter_pkg: FSM state encoding and counter constants shared by the
// period meter block.
package period_meter_pkg;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

    // Largest value a width-bit counter can hold (2^width - 1), for width up to 63.
    function automatic longint unsigned sat_value(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/period_meter_if.sv
// period_meter_if: valid/ready result channel of the period meter.
// The master drives the measured period, the slave accepts it.
interface period_meter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             period_ready;

    modport master (
        output period,
        output period_valid,
        input  period_ready
    );

    modport slave (
        input  period,
        input  period_valid,
        output period_ready
    );
endinterface

// File: rtl/period_meter_edge_sync.sv
// edge_sync: synchronises the asynchronous measured signal, optionally
// debounces it, and emits a one-cycle strobe on each rising edge.
// The glitch filter is compiled in only when PERIOD_METER_FILTER_EN is defined.
module edge_sync #(
    parameter int SYNC_STAGES = 2
`ifdef PERIOD_METER_FILTER_EN
    ,
    parameter int FILTER_LEN  = 3
`endif
) (
    input  logic clk_in,
    input  logic rstn,
    input  logic sig_in,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   lvl;
    logic                   lvl_prev_q;

    // Multi-flop synchroniser; the chain needs at least two stages.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the value from before the edge, independent of statement order.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef PERIOD_METER_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] stab_q;
    logic          lvl_q;

    // Level follows sync only after it has held a new value FILTER_LEN cycles.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            lvl_q  <= 1'b0;
            stab_q <= '0;
        end else if (sync == lvl_q) begin
            stab_q <= '0;
        end else if (stab_q == CW'(FILTER_LEN - 1)) begin
            lvl_q  <= sync;
            stab_q <= '0;
        end else begin
            stab_q <= stab_q + 1'b1;
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = sync;
`endif

    // Previous level, for rising-edge detection.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            lvl_prev_q <= 1'b0;
        end else begin
            lvl_prev_q <= lvl;
        end
    end

    assign rise = lvl & ~lvl_prev_q;

endmodule

// File: rtl/period_meter.sv
// period_meter: counts clk_in cycles between consecutive rising edges of the
// asynchronous input sig_in and offers each result on a valid/ready channel.
// Define PERIOD_METER_FILTER_EN to compile in the front-end glitch filter.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic           clk_in,
    input  logic           rstn,
    input  logic           enable,
    input  logic           sig_in,
    period_meter_if.master out_if,
    output logic           timeout,
    output logic           overrun,
    output logic           busy
);
    localparam logic [WIDTH-1:0] CNT_SAT = WIDTH'(sat_value(WIDTH));
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             rise;
    logic             capture;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef PERIOD_METER_FILTER_EN
        ,
        .FILTER_LEN (FILTER_LEN)
`endif
    ) u_edge_sync (
        .clk_in(clk_in),
        .rstn  (rstn),
        .sig_in(sig_in),
        .rise  (rise)
    );

    // Next-state for the FSM, period counter and result register.
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = valid_q;
        capture  = 1'b0;
        timeout  = 1'b0;
        overrun  = 1'b0;

        // A completed handshake retires the held result.
        if (valid_q && out_if.period_ready) begin
            valid_d = 1'b0;
        end

        if (!enable) begin
            // Disabling abandons the measurement and any pending result.
            state_d = ST_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        capture = 1'b1;
                        cnt_d   = CNT_ONE;
                    end else if (cnt_q == CNT_SAT) begin
                        // Input stalled: give up and wait for a fresh first edge.
                        timeout = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_ARMED;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // New result: load it unless the consumer is still holding the old one.
        if (capture) begin
            if (valid_q && !out_if.period_ready) begin
                overrun = 1'b1;
            end else begin
                period_d = cnt_q;
                valid_d  = 1'b1;
            end
        end
    end

    // State, counter and result registers.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
        end
    end

    assign out_if.period       = period_q;
    assign out_if.period_valid = valid_q;
    assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: self-checking bench for period_meter. Expected periods are
// the distances between the bench's own rising edges on sig_in.
module tb_period_meter;

    localparam int W  = 16;
    localparam int W8 = 8;
    localparam int SS = 2;
    localparam int FL = 3;
`ifdef PERIOD_METER_FILTER_EN
    localparam int MIN_W = FL;
    localparam int LAT   = 1 + SS + FL;
`else
    localparam int MIN_W = 1;
    localparam int LAT   = 1 + SS;
`endif

    logic clk_in = 1'b0;
    logic rstn   = 1'b1;
    logic enable = 1'b0;
    logic sig_in = 1'b0;
    logic timeout, overrun, busy;
    logic timeout8, overrun8, busy8;

    period_meter_if #(.WIDTH(W))  pif ();
    period_meter_if #(.WIDTH(W8)) pif8 ();

    period_meter #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(FL)) dut (
        .clk_in (clk_in),
        .rstn   (rstn),
        .enable (enable),
        .sig_in (sig_in),
        .out_if (pif),
        .timeout(timeout),
        .overrun(overrun),
        .busy   (busy)
    );

    period_meter #(.WIDTH(W8), .SYNC_STAGES(SS), .FILTER_LEN(FL)) dut8 (
        .clk_in (clk_in),
        .rstn   (rstn),
        .enable (enable),
        .sig_in (sig_in),
        .out_if (pif8),
        .timeout(timeout8),
        .overrun(overrun8),
        .busy   (busy8)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Observed traffic, recorded away from the active edge.
    typedef struct { int val; int cyc; } acc_t;
    acc_t got[$];
    acc_t got8[$];
    int   ovr_cnt  = 0;
    int   ovr8_cnt = 0;
    int   tmo_cnt  = 0;
    int   tmo8_cyc[$];

    always @(negedge clk_in) begin
        if (pif.period_valid && pif.period_ready)   got.push_back('{int'(pif.period), cyc});
        if (pif8.period_valid && pif8.period_ready) got8.push_back('{int'(pif8.period), cyc});
        if (overrun)  ovr_cnt++;
        if (overrun8) ovr8_cnt++;
        if (timeout)  tmo_cnt++;
        if (timeout8) tmo8_cyc.push_back(cyc);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int rises[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Square wave: n rising edges, each high for hi and low for lo cycles.
    task automatic square(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            rises.push_back(cyc);
            step(hi);
            sig_in = 1'b0;
            step(lo);
        end
    endtask

    // Disable long enough for the front end to settle low, then re-arm.
    task automatic restart();
        enable = 1'b0;
        sig_in = 1'b0;
        step(12);
        enable = 1'b1;
        step(2);
    endtask

    // Run a square wave with ready held high and check every accepted result.
    task automatic run_vec(input string name, input int hi, input int lo, input int n, input int exp);
        int g0, o0, t0;
        g0 = got.size();
        o0 = ovr_cnt;
        t0 = tmo_cnt;
        rises.delete();
        square(hi, lo, n);
        step(LAT + 4);
        check({name, " result count"}, got.size() - g0, n - 1);
        for (int i = g0; i < got.size(); i++) check({name, " period"}, got[i].val, exp);
        if (got.size() > g0)
            check({name, " first result after second edge"}, got[g0].cyc > rises[1], 1);
        check({name, " no overrun"}, ovr_cnt - o0, 0);
        check({name, " no timeout"}, tmo_cnt - t0, 0);
    endtask

    typedef struct { string name; int hi; int lo; int n; int exp_p; } vec_t;
    vec_t tbl[$];

    initial begin
        int g0, o0, g8, t8, r0, hi, lo;

        pif.period_ready  = 1'b1;
        pif8.period_ready = 1'b1;

        // Asynchronous reset and reset values.
        #2 rstn = 1'b0;
        #1;
        check("reset period", pif.period, 0);
        check("reset period_valid", pif.period_valid, 0);
        check("reset timeout", timeout, 0);
        check("reset overrun", overrun, 0);
        check("reset busy", busy, 0);
        check("reset busy w8", busy8, 0);
        step(3);
        rstn = 1'b1;
        step(2);

        // Table of square waves and their expected period.
        tbl.push_back('{"p10", 5, 5, 6, 10});
        tbl.push_back('{"p6", 3, 3, 5, 6});
        tbl.push_back('{"p7", 3, 4, 5, 7});
        tbl.push_back('{"p37", 18, 19, 4, 37});
        tbl.push_back('{"p101", 60, 41, 3, 101});
        tbl.push_back('{"p254", 127, 127, 3, 254});
`ifndef PERIOD_METER_FILTER_EN
        tbl.push_back('{"p2", 1, 1, 8, 2});
        tbl.push_back('{"p3a", 1, 2, 6, 3});
        tbl.push_back('{"p3b", 2, 1, 6, 3});
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            restart();
            run_vec(tbl[i].name, tbl[i].hi, tbl[i].lo, tbl[i].n, tbl[i].exp_p);
        end

`ifdef PERIOD_METER_FILTER_EN
        // Period-50 signal with one-cycle glitches in both phases.
        restart();
        g0 = got.size();
        for (int i = 0; i < 4; i++) begin
            sig_in = 1'b1; step(12);
            sig_in = 1'b0; step(1);
            sig_in = 1'b1; step(12);
            sig_in = 1'b0; step(12);
            sig_in = 1'b1; step(1);
            sig_in = 1'b0; step(12);
        end
        step(LAT + 4);
        check("glitch result count", got.size() - g0, 3);
        for (int i = g0; i < got.size(); i++) check("glitch period", got[i].val, 50);
`endif

        // Consumer stalls for 100 cycles on a period-37 input.
        pif.period_ready = 1'b0;
        restart();
        g0 = got.size();
        o0 = ovr_cnt;
        rises.delete();
        fork
            square(18, 19, 5);
            begin
                step(90);
                check("stall held valid", pif.period_valid, 1);
                check("stall held period", pif.period, 37);
                step(10);
                pif.period_ready = 1'b1;
            end
        join
        r0 = rises[0];
        step(LAT + 4);
        check("stall overrun pulses", ovr_cnt - o0, 1);
        check("stall result count", got.size() - g0, 3);
        for (int i = g0; i < got.size(); i++) check("stall period", got[i].val, 37);
        if (got.size() > g0) check("stall first accept after ready", got[g0].cyc >= r0 + 100, 1);

        // Enable dropped while a result is pending.
        pif.period_ready = 1'b0;
        restart();
        square(5, 5, 3);
        step(LAT + 2);
        check("drop pending valid", pif.period_valid, 1);
        g0 = got.size();
        enable = 1'b0;
        step(1);
        check("drop period_valid", pif.period_valid, 0);
        check("drop busy", busy, 0);
        pif.period_ready = 1'b1;
        step(1);
        check("drop no stale handshake", got.size() - g0, 0);
        enable = 1'b1;
        step(2);
        run_vec("reenable", 5, 5, 4, 10);

        // Saturation on the 8-bit instance, then recovery.
        restart();
        g8 = got8.size();
        t8 = tmo8_cyc.size();
        o0 = tmo_cnt;
        r0 = cyc;
        sig_in = 1'b1;
        step(5);
        sig_in = 1'b0;
        step(300);
        check("w8 timeout pulses", tmo8_cyc.size() - t8, 1);
        if (tmo8_cyc.size() > t8) check("w8 timeout cycle", tmo8_cyc[t8] - r0, LAT + 254);
        check("w8 no result on timeout", got8.size() - g8, 0);
        check("w8 busy while armed", busy8, 1);
        check("w16 no timeout", tmo_cnt - o0, 0);
        square(10, 10, 2);
        step(LAT + 4);
        check("w8 result count after timeout", got8.size() - g8, 1);
        if (got8.size() > g8) check("w8 period after timeout", got8[g8].val, 20);
        check("w8 no overrun", ovr8_cnt, 0);

        // Randomised edge spacing against the edge-distance model.
        restart();
        g0 = got.size();
        rises.delete();
        for (int i = 0; i < 30; i++) begin
            hi = $urandom_range(20, MIN_W);
            lo = $urandom_range(20, MIN_W);
            square(hi, lo, 1);
        end
        step(LAT + 4);
        check("random result count", got.size() - g0, 29);
        for (int i = 0; i < 29 && g0 + i < got.size(); i++)
            check("random period", got[g0 + i].val, rises[i + 1] - rises[i]);

        // Reset asserted between clock edges while a result is held.
        pif.period_ready = 1'b0;
        restart();
        square(5, 5, 3);
        step(LAT + 2);
        check("async pre valid", pif.period_valid, 1);
        @(posedge clk_in);
        #3 rstn = 1'b0;
        #1;
        check("async period", pif.period, 0);
        check("async period_valid", pif.period_valid, 0);
        check("async busy", busy, 0);
        check("async timeout", timeout, 0);
        check("async overrun", overrun, 0);
        step(2);
        rstn = 1'b1;
        pif.period_ready = 1'b1;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period of an external pulse train, such as a divided clock or strobe, in reference clock cycles. The input is asynchronous. The block synchronises it, detects rising edges and counts `clk_in` cycles between consecutive edges. Each completed measurement is presented on a valid/ready output for the sniffer's capture or report logic. It is the consumer-side counterpart of the team's clock-divider pulse generators and is used to check their output frequency in-system.

## Interface
Parameters:
- `WIDTH`, default 16: period counter and result width.
- `SYNC_STAGES`, default 2: synchroniser flops on `sig_in`; must be at least 2.
- `FILTER_LEN`, default 3: stability length for the glitch filter; only used when the filter is compiled in.

Ports:
- `clk_in`, input, 1: reference clock; all logic is on its rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: measurement enable.
- `sig_in`, input, 1: asynchronous signal being measured.
- `period`, output, WIDTH: measured period in `clk_in` cycles.
- `period_valid`, output, 1: `period` is valid.
- `period_ready`, input, 1: consumer accepts `period`.
- `timeout`, output, 1: one-cycle pulse when the counter saturates.
- `overrun`, output, 1: one-cycle pulse when a measurement is dropped.
- `busy`, output, 1: the FSM is not in IDLE.

## Operation
- Front end: `sig_in` passes through a SYNC_STAGES-flop synchroniser to give `sync`. When filtered, `sync` goes through the filter to give `lvl`; otherwise `lvl` equals `sync`. A rising edge is detected when `lvl` is 1 and the previous `lvl` is 0.
- FSM states are IDLE, ARMED and MEASURE.
  - IDLE: entered on reset or whenever `enable` is 0. The counter is 0 and `period_valid` is cleared. Moves to ARMED when `enable` is 1.
  - ARMED: waits for the first rising edge. On an edge, `cnt` is set to 1 and the FSM moves to MEASURE.
  - MEASURE: `cnt` increments by 1 each cycle. On a rising edge, the current `cnt` is captured and `cnt` is set back to 1; the FSM stays in MEASURE.
- With edges at cycles t and t+P, the captured `period` is exactly P.
- Saturation: if `cnt` equals 2^WIDTH-1 with no edge:
  - `timeout` pulses for 1 cycle;
  - no result is emitted;
  - the FSM moves to ARMED.
- Output register:
  - A captured value is loaded into `period` and `period_valid` is set to 1.
  - `period_valid` and `period` hold until `period_valid` and `period_ready` are both 1.
  - If a capture occurs while `period_valid` is 1 and `period_ready` is 0, the new value is dropped. `overrun` pulses for 1 cycle and the held value is unchanged.
  - If a capture occurs in the same cycle as a handshake, the new value is loaded and `period_valid` stays 1.
- `enable` dropping mid-measurement: on the next edge the FSM is in IDLE, `cnt` is 0 and `period_valid` is 0. Any pending value is discarded.
- Smallest resolvable period is 2 cycles, where `lvl` alternates. Faster input is undersampled and its result is not specified.

## Timing
- Reset values: `period` is 0; `period_valid`, `timeout`, `overrun` and `busy` are 0; FSM is IDLE; synchroniser and filter flops are 0.
- Latency from the first `clk_in` edge that samples `sig_in` high to the detected edge is SYNC_STAGES cycles.
- `period_valid` rises 1 cycle after the detected edge.
- The front-end delay is constant, so it does not bias `period`.
- `busy` is registered and follows the FSM state with no extra delay.
- The handshake follows AXI-style rules: `period_valid` never depends combinationally on `period_ready`.

## Configuration
- `PERIOD_METER_FILTER_EN` defined:
  - `lvl` changes only after `sync` has held a new value for FILTER_LEN consecutive cycles;
  - pulses shorter than FILTER_LEN cycles are ignored;
  - this adds FILTER_LEN cycles of latency;
  - the minimum period becomes 2*FILTER_LEN.
- Not defined: `lvl` equals `sync` and the filter logic is absent.

## Structure
- Package `period_meter_pkg` holds:
  - the FSM state encoding (IDLE=0, ARMED=1, MEASURE=2);
  - the saturation constant 2^WIDTH-1, as a function of WIDTH.
- Sub-module `edge_sync` holds the synchroniser, the optional filter and the rising-edge detector. Its output is a 1-cycle `rise` strobe.
- The top module holds the FSM, the counter and the output register.

## Test plan
- Reset with `enable`=1 and `sig_in` toggling at period 10, `period_ready`=1 → the first result is 10, then 10 repeatedly; nothing is emitted before the second edge.
- Input period 37 with `period_ready` held 0 for 100 cycles → `period`=37 is held; `overrun` pulses on each later capture; the first value is seen after `period_ready` goes to 1.
- WIDTH=8 with a single edge then `sig_in` held low → `timeout` pulses 254 cycles after the first captured edge (when `cnt` reaches 255); the FSM is in ARMED; the next two edges 20 cycles apart give 20.
- `enable` drops mid-measurement with `period_valid`=1 → `period_valid` and `busy` are 0 on the next cycle; after re-enable, the first result needs two fresh edges.
- Alternating period 2 → results are 2 without the filter. With the filter and FILTER_LEN=3, 1-cycle glitches on a period-50 signal give exactly 50.
- `rstn` asserted asynchronously mid-capture → all outputs are 0 immediately, before the next `clk_in` edge.
